// File: rtl/jpeg_lift_ram.sv
// jpeg_lift_ram: one LeGall 5/3 lifting-step unit (predict/update,
// forward/inverse) with a registered 16-bit result, alongside a simple
// dual-port sample RAM (one write port, one read port) that buffers
// samples between lifting passes.
module jpeg_lift_ram #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 64,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic signed [15:0]  l_s,
    input  logic signed [15:0]  r_s,
    input  logic signed [15:0]  s_s,
    input  logic                e_o_s,
    input  logic                f_i_s,
    output logic signed [15:0]  res_s,
    input  logic [AW-1:0]       i_Wr_Addr,
    input  logic                i_Wr_DV,
    input  logic [WIDTH-1:0]    i_Wr_Data,
    input  logic [AW-1:0]       i_Rd_Addr,
    input  logic                i_Rd_En,
    output logic                o_Rd_DV,
    output logic [WIDTH-1:0]    o_Rd_Data
);

    // Predict term: floor(sum / 2).
    function automatic logic signed [17:0] predict_term(input logic signed [16:0] sum);
        logic signed [17:0] t;
        t = {sum[16], sum};
        return t >>> 1;
    endfunction

    // Update term: floor((sum + 2) / 4); 18 bits keep sum + 2 from overflowing.
    function automatic logic signed [17:0] update_term(input logic signed [16:0] sum);
        logic signed [17:0] t;
        t = {sum[16], sum} + 18'sd2;
        return t >>> 2;
    endfunction

    // Two's-complement wrap of the 18-bit result back to 16 bits.
    function automatic logic signed [15:0] wrap16(input logic signed [17:0] v);
        return v[15:0];
    endfunction

    logic signed [16:0] sum_p0;
    logic signed [17:0] s_ext_p0;
    logic signed [17:0] term_p0;
    logic signed [17:0] full_p0;
    logic               add_p0;
    logic signed [15:0] res_p1;
    logic [WIDTH-1:0]   mem [DEPTH];

    // Stage p0: combinational lifting step. Forward predict and inverse
    // update subtract the term; the other two cases add it.
    always_comb begin
        sum_p0   = $signed({l_s[15], l_s}) + $signed({r_s[15], r_s});
        s_ext_p0 = $signed({{2{s_s[15]}}, s_s});
        term_p0  = e_o_s ? predict_term(sum_p0) : update_term(sum_p0);
        add_p0   = e_o_s ^ f_i_s;
        full_p0  = add_p0 ? (s_ext_p0 + term_p0) : (s_ext_p0 - term_p0);
    end

    // Stage p1: result and read-port registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_p1    <= '0;
            o_Rd_DV   <= 1'b0;
            o_Rd_Data <= '0;
        end else begin
            res_p1    <= wrap16(full_p0);
            o_Rd_DV   <= i_Rd_En;
            o_Rd_Data <= mem[i_Rd_Addr];
        end
    end

    // Memory write port; contents survive reset, writes are dropped during it.
    // Reading the old word above with nonblocking updates gives read-before-write.
    always_ff @(posedge clk) begin
        if (rst_n && i_Wr_DV) begin
            mem[i_Wr_Addr] <= i_Wr_Data;
        end
    end

    assign res_s = res_p1;

endmodule

// File: tb/tb_jpeg_lift_ram.sv
// Directed bench for jpeg_lift_ram: a behavioural reference model checked
// every cycle, plus hand-computed literal expectations.
module tb_jpeg_lift_ram;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic signed [15:0] l_s = '0;
    logic signed [15:0] r_s = '0;
    logic signed [15:0] s_s = '0;
    logic               e_o_s = 1'b0;
    logic               f_i_s = 1'b0;
    logic signed [15:0] res_s;
    logic [5:0]         i_Wr_Addr = '0;
    logic               i_Wr_DV = 1'b0;
    logic [15:0]        i_Wr_Data = '0;
    logic [5:0]         i_Rd_Addr = '0;
    logic               i_Rd_En = 1'b0;
    logic               o_Rd_DV;
    logic [15:0]        o_Rd_Data;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    jpeg_lift_ram #(.WIDTH(16), .DEPTH(64)) dut (
        .clk(clk), .rst_n(rst_n),
        .l_s(l_s), .r_s(r_s), .s_s(s_s), .e_o_s(e_o_s), .f_i_s(f_i_s),
        .res_s(res_s),
        .i_Wr_Addr(i_Wr_Addr), .i_Wr_DV(i_Wr_DV), .i_Wr_Data(i_Wr_Data),
        .i_Rd_Addr(i_Rd_Addr), .i_Rd_En(i_Rd_En),
        .o_Rd_DV(o_Rd_DV), .o_Rd_Data(o_Rd_Data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Floor division for a positive divisor, done with integer arithmetic.
    function automatic int fdiv(input int a, input int b);
        int q;
        q = a / b;
        if ((a % b != 0) && (a < 0)) q = q - 1;
        return q;
    endfunction

    function automatic logic [15:0] lift_ref(input int l, input int r, input int s,
                                            input bit e, input bit f);
        int sum, term, res;
        sum  = l + r;
        term = e ? fdiv(sum, 2) : fdiv(sum + 2, 4);
        if (e) res = f ? s - term : s + term;
        else   res = f ? s + term : s - term;
        return res[15:0];
    endfunction

    // Reference model state.
    logic [15:0] m_res;
    logic        m_dv;
    logic [15:0] m_data;
    bit          m_known;
    logic [15:0] mem_m [64];
    bit          mem_v [64];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_res   <= '0;
            m_dv    <= 1'b0;
            m_data  <= '0;
            m_known <= 1'b1;
        end else begin
            m_res   <= lift_ref(int'(l_s), int'(r_s), int'(s_s), e_o_s, f_i_s);
            m_dv    <= i_Rd_En;
            m_known <= mem_v[i_Rd_Addr];
            m_data  <= mem_m[i_Rd_Addr];
            if (i_Wr_DV) begin
                mem_m[i_Wr_Addr] <= i_Wr_Data;
                mem_v[i_Wr_Addr] <= 1'b1;
            end
        end
    end

    // Compare process: outputs against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_res", res_s, m_res);
            chk("model_rd_dv", {15'b0, o_Rd_DV}, {15'b0, m_dv});
            if (m_known) chk("model_rd_data", o_Rd_Data, m_data);
        end
    end

    task automatic lift(input logic signed [15:0] l, input logic signed [15:0] r,
                        input logic signed [15:0] s, input bit e, input bit f,
                        input logic [15:0] exp, input string nm);
        @(negedge clk);
        l_s = l; r_s = r; s_s = s; e_o_s = e; f_i_s = f;
        @(negedge clk);
        chk(nm, res_s, exp);
    endtask

    task automatic rd_one(input logic [5:0] a, input logic [15:0] exp, input string nm);
        @(negedge clk);
        i_Rd_Addr = a; i_Rd_En = 1'b1;
        @(negedge clk);
        i_Rd_En = 1'b0;
        chk({nm, "_dv"}, {15'b0, o_Rd_DV}, 16'd1);
        chk(nm, o_Rd_Data, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #2;
        chk("reset_res", res_s, 16'd0);
        chk("reset_rd_dv", {15'b0, o_Rd_DV}, 16'd0);
        chk("reset_rd_data", o_Rd_Data, 16'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk_en = 1'b1;

        // Lifting: predict/update, forward/inverse, rounding and wrap
        lift(16'sd215, 16'sd217, 16'sd216, 1'b1, 1'b1, 16'd0,   "pred_fwd");
        lift(16'sd215, 16'sd217, 16'sd216, 1'b1, 1'b0, 16'd432, "pred_inv");
        lift(16'sd215, 16'sd217, 16'sd216, 1'b0, 1'b1, 16'd324, "upd_fwd");
        lift(16'sd215, 16'sd217, 16'sd216, 1'b0, 1'b0, 16'd108, "upd_inv");
        lift(16'sd216, 16'sd215, 16'sd216, 1'b1, 1'b1, 16'd1,   "pred_round");
        lift(-16'sd3,  16'sd0,   16'sd0,   1'b1, 1'b0, 16'hFFFE, "pred_neg_floor");
        lift(16'sh7FFF, 16'sh7FFF, 16'sh7FFF, 1'b1, 1'b0, 16'hFFFE, "pred_wrap");
        lift(-16'sd5,  -16'sd2,  16'sd10,  1'b0, 1'b1, 16'd8,   "upd_neg_floor");

        // RAM fill: addr k holds 55+k
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            i_Wr_Addr = 6'(k); i_Wr_Data = 16'(55 + k); i_Wr_DV = 1'b1;
        end
        @(negedge clk);
        i_Wr_DV = 1'b0;

        // Streamed read of every address, one result per cycle
        for (int k = 0; k <= 64; k++) begin
            @(negedge clk);
            if (k > 0) begin
                chk("fill_rd_dv", {15'b0, o_Rd_DV}, 16'd1);
                chk("fill_rd_data", o_Rd_Data, 16'(55 + k - 1));
            end
            if (k < 64) begin
                i_Rd_Addr = 6'(k); i_Rd_En = 1'b1;
            end else begin
                i_Rd_En = 1'b0;
            end
        end
        @(negedge clk);
        chk("rd_dv_drop", {15'b0, o_Rd_DV}, 16'd0);

        // Collision: read-before-write on the same address
        i_Wr_Addr = 6'd1; i_Wr_Data = 16'd84; i_Wr_DV = 1'b1;
        i_Rd_Addr = 6'd1; i_Rd_En = 1'b1;
        @(negedge clk);
        i_Wr_DV = 1'b0; i_Rd_En = 1'b0;
        chk("collide_old", o_Rd_Data, 16'd56);
        rd_one(6'd1, 16'd84, "collide_new");

        // Independent read and write to different addresses in one cycle
        @(negedge clk);
        i_Wr_Addr = 6'd10; i_Wr_Data = 16'h1234; i_Wr_DV = 1'b1;
        i_Rd_Addr = 6'd20; i_Rd_En = 1'b1;
        @(negedge clk);
        i_Wr_DV = 1'b0; i_Rd_En = 1'b0;
        chk("indep_rd", o_Rd_Data, 16'd75);
        rd_one(6'd10, 16'h1234, "indep_wr");

        // Asynchronous reset mid-stream
        @(negedge clk);
        l_s = 16'sd100; r_s = 16'sd100; s_s = 16'sd50; e_o_s = 1'b1; f_i_s = 1'b0;
        i_Rd_Addr = 6'd3; i_Rd_En = 1'b1;
        @(posedge clk);
        #2;
        chk("pre_reset_res", res_s, 16'd150);
        rst_n = 1'b0;
        #1;
        chk("async_rst_res", res_s, 16'd0);
        chk("async_rst_rd_dv", {15'b0, o_Rd_DV}, 16'd0);
        chk("async_rst_rd_data", o_Rd_Data, 16'd0);
        @(negedge clk);
        i_Rd_En = 1'b0;
        i_Wr_Addr = 6'd2; i_Wr_Data = 16'd999; i_Wr_DV = 1'b1;
        @(negedge clk);
        i_Wr_DV = 1'b0;
        rst_n = 1'b1;
        rd_one(6'd2, 16'd57, "post_reset_rd");

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/jpeg_lift_ram.md
# jpeg_lift_ram

Combined datapath element for the JPEG wavelet path. It holds one LeGall 5/3 lifting-step unit (predict/update, forward/inverse) with a registered 16-bit signed result, plus a simple dual-port sample RAM with one write port and one read port. Both share a single clock. Several instances run in parallel, one per row or column lane, and the RAM buffers samples between lifting passes.

## Interface
- WIDTH, 16, RAM data width in bits.
- DEPTH, 64, RAM word count; the address width is $clog2(DEPTH).
- clk  in  1  clock; all registers update on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- l_s  in  16 signed  left neighbour sample.
- r_s  in  16 signed  right neighbour sample.
- s_s  in  16 signed  centre sample being lifted.
- e_o_s  in  1  1 = predict (odd) step, 0 = update (even) step.
- f_i_s  in  1  1 = forward transform, 0 = inverse transform.
- res_s  out  16 signed  registered lifting result.
- i_Wr_Addr  in  $clog2(DEPTH)  write address.
- i_Wr_DV  in  1  write enable.
- i_Wr_Data  in  WIDTH  write data.
- i_Rd_Addr  in  $clog2(DEPTH)  read address.
- i_Rd_En  in  1  read request.
- o_Rd_DV  out  1  read data valid.
- o_Rd_Data  out  WIDTH  read data.

## Operation
- Lifting arithmetic:
  - Sum = l_s + r_s, sign-extended to 17 bits, so the sum never overflows.
  - Predict (e_o_s=1): term = sum >>> 1 (arithmetic shift, floor).
    - f_i_s=1: res = s_s − term.
    - f_i_s=0: res = s_s + term.
  - Update (e_o_s=0): term = (sum + 2) >>> 2 (arithmetic shift, floor).
    - f_i_s=1: res = s_s + term.
    - f_i_s=0: res = s_s − term.
  - The final add/subtract is done at 18 bits and truncated to 16 bits (two's-complement wrap). There is no saturation.
- The lifting unit computes every cycle. There is no enable; res_s is simply the registered function of the inputs.
- RAM write: on a rising edge with i_Wr_DV=1, mem[i_Wr_Addr] <= i_Wr_Data.
- RAM read:
  - On every rising edge, o_Rd_Data <= mem[i_Rd_Addr], regardless of i_Rd_En.
  - On every rising edge, o_Rd_DV <= i_Rd_En.
  - Consumers qualify o_Rd_Data with o_Rd_DV.
- Same address written and read in the same cycle: the read returns the old contents (read-before-write). The new value is visible from the next read onward.
- Addresses are exactly $clog2(DEPTH) bits; no out-of-range handling is needed for power-of-two DEPTH.
- Memory contents are not cleared by reset and are undefined until written.

## Timing
- Reset, asynchronous while rst_n=0: res_s=0, o_Rd_DV=0, o_Rd_Data=0.
  - Writes are ignored while in reset.
  - Release takes effect at the first rising edge after rst_n rises.
- Lifting latency: 1 cycle. Inputs sampled at edge N appear on res_s after edge N. Throughput is one result per cycle.
- Read latency: 1 cycle from address/enable to o_Rd_Data/o_Rd_DV.
- Write latency: data is readable by a read issued in the cycle after the write.
- Reset asserted mid-operation:
  - res_s, o_Rd_DV and o_Rd_Data clear immediately.
  - RAM contents are retained.
- Simultaneous read and write to different addresses are fully independent.

## Test plan
- Predict, forward: l=215, r=217, s=216, e=1, f=1 -> res_s=0 one cycle later. Same inputs with f=0 -> res_s=432.
- Update: l=215, r=217, s=216, e=0, f=1 -> res_s=324 (term=108). With f=0 -> res_s=108.
- Rounding and sign:
  - l=216, r=215, s=216, e=1, f=1 -> res_s=1.
  - l=−3, r=0, s=0, e=1, f=0 -> res_s=−2 (floor of −1.5).
  - l=0x7FFF, r=0x7FFF, s=0x7FFF, e=1, f=0 -> res_s wraps to 0xFFFE.
- RAM fill and read: write 64 words with addr k = 55+k. Read addresses 0..63 with i_Rd_En=1 -> o_Rd_Data=55..118 with o_Rd_DV=1, each one cycle after its address.
- Collision: same cycle, write 84 to address 1 and read address 1 -> o_Rd_Data=56. A later read of address 1 -> 84.
- Reset: assert rst_n=0 mid-stream, asynchronously -> res_s=0 and o_Rd_DV=0 immediately. After release, a read of address 2 still returns 57.
